seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised multi-digit successor to the single-digit hex-to-segment decoder.
- Latches a packed hex value and time-multiplexes it onto one shared segment bus, driving a one-hot digit-select bus.
- Adds per-digit decimal points, per-digit blanking, leading-zero suppression, anti-ghost dead time and tear-free frame-synchronous update.
- Sits between the keyboard/value datapath and the board's 7-segment pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- SCAN_DIV, 50000, clk cycles each digit is lit (≥2).
- DEAD_CYCLES, 8, clk cycles all digits are off between digits (0 = none).
- SEG_ACTIVE_LOW, 0, 1 inverts all seg outputs at the pin.
- DIG_ACTIVE_LOW, 0, 1 inverts all dig outputs at the pin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  packed nibbles; nibble k = digit k; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit; 1 = on.
- blank_in  in  DIGITS  per-digit force blank; 1 = blank.
- lz_en  in  1  leading-zero suppression enable.
- load  in  1  strobe: capture value/dp_in/blank_in/lz_en into the pending register.
- seg  out  [0:7]  segments a,b,c,d,e,f,g,dp; seg[0] = a.
- dig  out  DIGITS  one-hot digit enable.
- frame_start  out  1  one-cycle pulse when digit 0 becomes lit.

Behaviour:
- Reset (sync, active-high): pending and shadow registers cleared to 0; FSM in DEAD with digit index = DIGITS-1; prescaler = 0; seg = all off; dig = all off; frame_start = 0. Polarity parameters apply, so "off" is all-ones when the corresponding ACTIVE_LOW = 1.
- load: pending register captured at the clock edge where load = 1. Repeated loads overwrite; last one wins.
- Shadow update:
  - Shadow copies pending only in the cycle the index wraps DIGITS-1 -> 0 (DEAD -> ON for digit 0).
  - A load in that same cycle is not seen until the next frame.
  - Guarantees no mixed old/new digits within one frame.
- FSM states:
  - ON: digit idx lit for SCAN_DIV cycles, then go to DEAD.
  - DEAD: all dig off and seg off for DEAD_CYCLES cycles. Then idx = (idx+1) mod DIGITS, go to ON.
  - If DEAD_CYCLES = 0, DEAD is skipped: ON -> ON of the next digit with no gap.
- Outputs: seg and dig are registered and change on the same edge; no cycle where the new dig pairs with the old seg.
- frame_start is asserted in the first ON cycle of digit 0.
- Decode, seg[0:7], nibble -> pattern:
  - 0 -> 11111100, 1 -> 01100000, 2 -> 11011010, 3 -> 11110010
  - 4 -> 01100110, 5 -> 10110110, 6 -> 10111110, 7 -> 11100000
  - 8 -> 11111110, 9 -> 11110110, A -> 11101110, b -> 00111110
  - c -> 00011010, d -> 01111010, E -> 10011110, F -> 10001110
  - Bit 7 (dp) is taken from shadow dp, not from the table.
- Blanking priority, per digit:
  - blank_in = 1 -> segments a-g off; dp still follows dp_in.
  - Else, if lz_en = 1 and every nibble from the digit up to DIGITS-1 is 0, and the digit is not digit 0 -> a-g off.
  - Digit 0 is never suppressed by lz_en (value 0 shows "0").
- Refresh period: DIGITS*(SCAN_DIV+DEAD_CYCLES) cycles per frame. DIGITS = 1 is legal; dig stays at bit 0 during ON.
- Reset mid-scan: all outputs go off on the next edge; the scan restarts with digit 0 after DEAD_CYCLES; the shadow is cleared.

Decomposition:
- Package seg_pkg holds:
  - localparams for the 16 segment patterns and SEG_OFF = 8'b0;
  - state encoding ST_ON / ST_DEAD.
- One natural sub-module: hex7_decode, combinational nibble -> seg[0:6], reused per lit digit.
- FSM, prescaler, shadow registers and blanking logic stay in the top level.

Test Plan:
- Reset: rst high 3 cycles -> seg = 00000000, dig = 0000, frame_start = 0. With SEG_ACTIVE_LOW = 1 -> seg = 11111111.
- Basic scan (DIGITS = 4, SCAN_DIV = 4, DEAD_CYCLES = 2):
  - Stimulus: load value = 16'h12AF, dp_in = 4'b0100.
  - Next frame: dig 0001 seg 10001110 for 4 cycles, then 2 off cycles.
  - Then dig 0010 seg 11101110, dig 0100 seg 11011011, dig 1000 seg 01100000.
  - frame_start pulses every 24 cycles.
- Leading-zero suppression: value = 16'h0050, lz_en = 1.
  - Digits 3 and 2 show 00000000; digit 1 shows 10110110; digit 0 shows 11111100.
  - value = 0 -> only digit 0 shows "0".
- Tear-free update: assert load with 16'hFFFF while digit 2 is lit.
  - Digits 2 and 3 of the current frame still show old nibbles.
  - All digits show F only from the next frame_start.
- Blank and dead-time checks:
  - blank_in = 4'b0010, dp_in = 4'b0010 -> digit 1 seg = 00000001.
  - DEAD_CYCLES = 0 -> dig goes directly 0001 -> 0010 with no all-off cycle.
- Reset mid-frame: rst asserted during digit 2 ON.
  - Next edge: dig = 0000.
  - After release: digit 0 lit after DEAD_CYCLES, showing 0 (shadow cleared).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Segment patterns are written seg[0:7] = a,b,c,d,e,f,g,dp, so the leftmost bit is segment a.
package seg_pkg;

    localparam logic [0:7] SEG_OFF = 8'b0000_0000;

    localparam logic [0:7] SEG_0 = 8'b1111_1100;
    localparam logic [0:7] SEG_1 = 8'b0110_0000;
    localparam logic [0:7] SEG_2 = 8'b1101_1010;
    localparam logic [0:7] SEG_3 = 8'b1111_0010;
    localparam logic [0:7] SEG_4 = 8'b0110_0110;
    localparam logic [0:7] SEG_5 = 8'b1011_0110;
    localparam logic [0:7] SEG_6 = 8'b1011_1110;
    localparam logic [0:7] SEG_7 = 8'b1110_0000;
    localparam logic [0:7] SEG_8 = 8'b1111_1110;
    localparam logic [0:7] SEG_9 = 8'b1111_0110;
    localparam logic [0:7] SEG_A = 8'b1110_1110;
    localparam logic [0:7] SEG_B = 8'b0011_1110;
    localparam logic [0:7] SEG_C = 8'b0001_1010;
    localparam logic [0:7] SEG_D = 8'b0111_1010;
    localparam logic [0:7] SEG_E = 8'b1001_1110;
    localparam logic [0:7] SEG_F = 8'b1000_1110;

    typedef enum logic {
        ST_ON   = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the value datapath and the scan driver.
//   value/dp_in/blank_in/lz_en/load : display request, captured on load
//   seg/dig/frame_start             : pin-level scan outputs
interface seg_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                lz_en;
    logic                load;
    logic [0:7]          seg;
    logic [DIGITS-1:0]   dig;
    logic                frame_start;

    modport master (
        output value, dp_in, blank_in, lz_en, load,
        input  seg, dig, frame_start
    );

    modport slave (
        input  value, dp_in, blank_in, lz_en, load,
        output seg, dig, frame_start
    );
endinterface

// File: rtl/hex7_decode.sv
// Combinational hex nibble to segments a..g (seg_c[0] = a); dp is handled by the caller.
//   nibble : hex digit 0..F
//   seg_c  : active-high segment pattern a..g
module hex7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg_c
);

    always_comb begin
        seg_c = SEG_OFF[0:6];
        case (nibble)
            4'h0: seg_c = SEG_0[0:6];
            4'h1: seg_c = SEG_1[0:6];
            4'h2: seg_c = SEG_2[0:6];
            4'h3: seg_c = SEG_3[0:6];
            4'h4: seg_c = SEG_4[0:6];
            4'h5: seg_c = SEG_5[0:6];
            4'h6: seg_c = SEG_6[0:6];
            4'h7: seg_c = SEG_7[0:6];
            4'h8: seg_c = SEG_8[0:6];
            4'h9: seg_c = SEG_9[0:6];
            4'hA: seg_c = SEG_A[0:6];
            4'hB: seg_c = SEG_B[0:6];
            4'hC: seg_c = SEG_C[0:6];
            4'hD: seg_c = SEG_D[0:6];
            4'hE: seg_c = SEG_E[0:6];
            4'hF: seg_c = SEG_F[0:6];
            default: seg_c = SEG_OFF[0:6];
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with dead time and frame-synchronous update.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seg_scan_driver_if (request in, seg/dig/frame_start out)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEAD_CYCLES    = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [0:7]        SEG_POL = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_POL = {DIGITS{DIG_ACTIVE_LOW}};

    logic [DIGITS-1:0][3:0] pend_value, shd_value, src_value;
    logic [DIGITS-1:0]      pend_dp, shd_dp, src_dp;
    logic [DIGITS-1:0]      pend_blank, shd_blank, src_blank;
    logic                   pend_lz, shd_lz, src_lz;

    state_t            state;
    logic [IDX_W-1:0]  idx, idx_inc;
    logic [CNT_W-1:0]  cnt;
    logic              wrap, on_done, dead_done, go_on, go_dead;
    logic [DIGITS-1:0] lz_mask;
    logic              zero_run;
    logic [0:6]        dec_seg;
    logic [0:7]        seg_lit, seg_q;
    logic [DIGITS-1:0] dig_q;
    logic              fs_q;

    // Scan sequencing: every ON entry lights idx_inc; wrap marks the start of a new frame.
    assign wrap      = (idx == IDX_W'(DIGITS - 1));
    assign idx_inc   = wrap ? '0 : idx + IDX_W'(1);
    assign on_done   = (state == ST_ON) && (cnt == CNT_W'(SCAN_DIV - 1));
    assign dead_done = (state == ST_DEAD) &&
                       ((DEAD_CYCLES == 0) || (cnt == CNT_W'(DEAD_CYCLES - 1)));
    assign go_on     = dead_done || (on_done && (DEAD_CYCLES == 0));
    assign go_dead   = on_done && (DEAD_CYCLES != 0);

    // The digit about to light sees pending directly when it opens a new frame,
    // since the shadow is being loaded on that same edge.
    assign src_value = wrap ? pend_value : shd_value;
    assign src_dp    = wrap ? pend_dp    : shd_dp;
    assign src_blank = wrap ? pend_blank : shd_blank;
    assign src_lz    = wrap ? pend_lz    : shd_lz;

    // Leading-zero mask: digit k is dark when it and every digit above it are zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            zero_run   = zero_run & (src_value[k] == 4'h0);
            lz_mask[k] = src_lz & zero_run;
        end
    end

    hex7_decode u_dec (
        .nibble (src_value[idx_inc]),
        .seg_c  (dec_seg)
    );

    // Blanking overrides a..g only; dp always follows its own bit.
    always_comb begin
        seg_lit[0:6] = (src_blank[idx_inc] || lz_mask[idx_inc]) ? 7'b0 : dec_seg;
        seg_lit[7]   = src_dp[idx_inc];
    end

    // Scan FSM, request capture, shadow update and pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lz    <= 1'b0;
            shd_value  <= '0;
            shd_dp     <= '0;
            shd_blank  <= '0;
            shd_lz     <= 1'b0;
            state      <= ST_DEAD;
            idx        <= IDX_W'(DIGITS - 1);
            cnt        <= '0;
            seg_q      <= SEG_OFF ^ SEG_POL;
            dig_q      <= DIG_POL;
            fs_q       <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                pend_lz    <= bus.lz_en;
            end
            fs_q <= 1'b0;
            if (go_on) begin
                state <= ST_ON;
                cnt   <= '0;
                idx   <= idx_inc;
                seg_q <= seg_lit ^ SEG_POL;
                dig_q <= (DIGITS'(1) << idx_inc) ^ DIG_POL;
                fs_q  <= wrap;
                if (wrap) begin
                    shd_value <= pend_value;
                    shd_dp    <= pend_dp;
                    shd_blank <= pend_blank;
                    shd_lz    <= pend_lz;
                end
            end else if (go_dead) begin
                state <= ST_DEAD;
                cnt   <= '0;
                seg_q <= SEG_OFF ^ SEG_POL;
                dig_q <= DIG_POL;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dig         = dig_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (dead time 2 active-high, dead time 0 active-low)
// share one stimulus stream; a frame-timeline model predicts every cycle of both.
module tb_seg_scan_driver;

    localparam int unsigned D = 4;
    localparam int unsigned S = 4;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lz;
    } disp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        lz_en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;

    int         compared;
    int         mismatched;
    int         n [2];
    disp_t      pend;
    disp_t      shd [2];
    logic [0:7] dec_tab [16];

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(D)) bus0 ();
    seg_scan_driver_if #(.DIGITS(D)) bus1 ();

    assign bus0.value = value;  assign bus1.value = value;
    assign bus0.dp_in = dp_in;  assign bus1.dp_in = dp_in;
    assign bus0.blank_in = blank_in;  assign bus1.blank_in = blank_in;
    assign bus0.lz_en = lz_en;  assign bus1.lz_en = lz_en;
    assign bus0.load = load;    assign bus1.load = load;

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .DEAD_CYCLES(2),
                      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .DEAD_CYCLES(0),
                      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic int dead_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic pol_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [0:7] obs_seg(input int i);
        return (i == 0) ? bus0.seg : bus1.seg;
    endfunction

    function automatic logic [3:0] obs_dig(input int i);
        return (i == 0) ? bus0.dig : bus1.dig;
    endfunction

    function automatic logic obs_fs(input int i);
        return (i == 0) ? bus0.frame_start : bus1.frame_start;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s inst%0d n=%0d: observed %0h expected %0h", tag, i, n[i], obs, exp);
        end
    endtask

    // Pattern a displayed frame shows on digit d (active-high, before pin polarity).
    function automatic logic [0:7] pattern(input disp_t s, input int d);
        logic [0:7] p;
        logic [3:0] nib;
        bit         zero_run;
        nib = s.v[4*d +: 4];
        p = dec_tab[nib];
        zero_run = 1'b1;
        for (int k = d; k < int'(D); k++)
            if (s.v[4*k +: 4] != 4'h0) zero_run = 1'b0;
        if (s.bl[d] || (s.lz && zero_run && d != 0)) p[0:6] = 7'b0;
        p[7] = s.dp[d];
        return p;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int off0;
            int per;
            off0 = (dead_of(i) == 0) ? 1 : dead_of(i);
            per  = int'(D) * (int'(S) + dead_of(i));
            if (rst) begin
                n[i]   = 0;
                shd[i] = '{16'h0, 4'h0, 4'h0, 1'b0};
            end else begin
                n[i]++;
                if (n[i] >= off0 && ((n[i] - off0) % per) == 0) shd[i] = pend;
            end
        end
        if (rst) pend = '{16'h0, 4'h0, 4'h0, 1'b0};
        else if (load) pend = '{value, dp_in, blank_in, lz_en};
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            int off0;
            int slot;
            int m;
            int d;
            int w;
            logic [0:7] es;
            logic [3:0] ed;
            logic       ef;
            off0 = (dead_of(i) == 0) ? 1 : dead_of(i);
            slot = int'(S) + dead_of(i);
            es = 8'h00;
            ed = 4'h0;
            ef = 1'b0;
            if (n[i] >= off0) begin
                m = n[i] - off0;
                d = (m / slot) % int'(D);
                w = m % slot;
                if (w < int'(S)) begin
                    ed = 4'(1 << d);
                    es = pattern(shd[i], d);
                    ef = (d == 0) && (w == 0);
                end
            end
            es = es ^ {8{pol_of(i)}};
            ed = ed ^ {4{pol_of(i)}};
            chk("seg", i, 32'(obs_seg(i)), 32'(es));
            chk("dig", i, 32'(obs_dig(i)), 32'(ed));
            chk("frame_start", i, 32'(obs_fs(i)), 32'(ef));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic pulse_load();
        load = 1'b1;
        step();
        load = 1'b0;
        step();
    endtask

    task automatic wait_dig(input int i, input logic [3:0] target, input int limit);
        int c;
        c = 0;
        while (obs_dig(i) !== target && c < limit) begin
            step();
            c++;
        end
        chk("wait_dig", i, 32'(obs_dig(i)), 32'(target));
    endtask

    task automatic wait_fs(input int i, input int limit, output int cyc);
        cyc = 0;
        while (obs_fs(i) !== 1'b1 && cyc < limit) begin
            step();
            cyc++;
        end
        chk("wait_fs", i, 32'(obs_fs(i)), 32'(1));
    endtask

    initial begin
        int c;
        compared   = 0;
        mismatched = 0;
        n[0] = 0;
        n[1] = 0;
        dec_tab = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
                    8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
                    8'b11111110, 8'b11110110, 8'b11101110, 8'b00111110,
                    8'b00011010, 8'b01111010, 8'b10011110, 8'b10001110};
        rst = 1'b1; load = 1'b0; lz_en = 1'b0;
        value = 16'h0; dp_in = 4'h0; blank_in = 4'h0;

        // reset state, both polarities
        repeat (3) step();
        chk("rst_seg_ah", 0, 32'(obs_seg(0)), 32'h00);
        chk("rst_seg_al", 1, 32'(obs_seg(1)), 32'hFF);
        chk("rst_dig_ah", 0, 32'(obs_dig(0)), 32'h0);

        // basic scan of 12AF with dp on digit 2
        rst = 1'b0;
        value = 16'h12AF; dp_in = 4'b0100;
        pulse_load();
        wait_fs(0, 100, c);
        chk("basic_d0", 0, 32'(obs_seg(0)), 32'(8'b10001110));
        wait_dig(0, 4'b0010, 40);
        chk("basic_d1", 0, 32'(obs_seg(0)), 32'(8'b11101110));
        wait_dig(0, 4'b0100, 40);
        chk("basic_d2", 0, 32'(obs_seg(0)), 32'(8'b11011011));
        wait_dig(0, 4'b1000, 40);
        chk("basic_d3", 0, 32'(obs_seg(0)), 32'(8'b01100000));
        wait_fs(0, 100, c);
        step();
        wait_fs(0, 100, c);
        chk("period_dead2", 0, 32'(c + 1), 32'(24));
        wait_fs(1, 100, c);
        step();
        wait_fs(1, 100, c);
        chk("period_dead0", 1, 32'(c + 1), 32'(16));

        // leading-zero suppression
        value = 16'h0050; dp_in = 4'h0; lz_en = 1'b1;
        pulse_load();
        wait_fs(0, 100, c);
        chk("lz_d0", 0, 32'(obs_seg(0)), 32'(8'b11111100));
        wait_dig(0, 4'b0010, 40);
        chk("lz_d1", 0, 32'(obs_seg(0)), 32'(8'b10110110));
        wait_dig(0, 4'b0100, 40);
        chk("lz_d2", 0, 32'(obs_seg(0)), 32'(8'b00000000));
        wait_dig(0, 4'b1000, 40);
        chk("lz_d3", 0, 32'(obs_seg(0)), 32'(8'b00000000));
        value = 16'h0000;
        pulse_load();
        wait_fs(0, 100, c);
        chk("lz_zero_d0", 0, 32'(obs_seg(0)), 32'(8'b11111100));
        wait_dig(0, 4'b0010, 40);
        chk("lz_zero_d1", 0, 32'(obs_seg(0)), 32'(8'b00000000));

        // tear-free update: load FFFF while digit 2 is lit
        value = 16'h1234; lz_en = 1'b0;
        pulse_load();
        wait_fs(0, 100, c);
        wait_dig(0, 4'b0100, 40);
        value = 16'hFFFF;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("tear_d2", 0, 32'(obs_seg(0)), 32'(8'b11011010));
        wait_dig(0, 4'b1000, 40);
        chk("tear_d3", 0, 32'(obs_seg(0)), 32'(8'b01100000));
        wait_fs(0, 100, c);
        chk("tear_new_d0", 0, 32'(obs_seg(0)), 32'(8'b10001110));

        // blank with dp kept
        value = 16'($urandom); blank_in = 4'b0010; dp_in = 4'b0010;
        pulse_load();
        wait_fs(0, 100, c);
        wait_dig(0, 4'b0010, 40);
        chk("blank_dp", 0, 32'(obs_seg(0)), 32'(8'b00000001));

        // no gap between digits when dead time is zero
        wait_dig(1, 4'b0111, 40);
        wait_dig(1, 4'b1110, 40);
        repeat (4) step();
        chk("dead0_next", 1, 32'(obs_dig(1)), 32'(4'b1101));

        // reset during digit 2
        wait_dig(0, 4'b0100, 40);
        rst = 1'b1;
        step();
        chk("midrst_dig", 0, 32'(obs_dig(0)), 32'h0);
        rst = 1'b0;
        wait_fs(0, 100, c);
        chk("midrst_delay", 0, 32'(c), 32'(2));
        chk("midrst_d0", 0, 32'(obs_seg(0)), 32'(8'b11111100));

        // randomized traffic
        for (int t = 0; t < 600; t++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++)
                value[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_en    = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
